size_exploration_seq_harness: RTL and testbench
===============================================

// Module: size_exploration_seq_harness
// PURPOSE
//  Successor to the combinational size-exploration harness: serially loads two WIDTH-bit
//  operands, runs a selectable arithmetic kernel (ADD, iterative shift-add MULT, or MAC)
//  under a start/busy/done FSM, and exposes the registered result byte-wise on the pins.
//  Sits as the user-project top of the exploration tile, with the standard TT pin set.
// PARAMETERS
//  WIDTH      8       operand width, 2..16
//  MODE       "MULT"  "ADD" | "MULT" | "MAC"
//  ACC_WIDTH  20      MAC accumulator width, >= 2*WIDTH (used only in MAC mode)
// PORTS
//  clk      in   1  single clock, all flops rising-edge
//  rst_n    in   1  asynchronous active-low reset
//  ena      in   1  1 = tile enabled; 0 = every register holds its value
//  ui_in    in   8  [0] ser_a, [1] ser_b, [2] shift_en, [3] start, [6:4] byte_sel, [7] acc_clr
//  uo_out   out  8  result byte selected by byte_sel
//  uio_in   in   8  unused
//  uio_out  out  8  [0] busy, [1] done, [2] overflow (sticky), [4:3] fsm state, [7:5] 0
//  uio_oe   out  8  constant 8'hFF
// BEHAVIOUR
//  - Reset (async assert, sync release): operands, result, accumulator, counter = 0; state IDLE;
//    uo_out = 0, uio_out = 0, uio_oe = 8'hFF.
//  - All ui_in bits are sampled on clk; no combinational path from ui_in to outputs except
//    the byte_sel mux.
//  - Load: in IDLE or DONE with shift_en=1, op_a <= {op_a[WIDTH-2:0], ser_a}, and likewise for
//    op_b (MSB first, WIDTH bits kept). shift_en is ignored during RUN.
//  - Start is edge-detected internally: a start_q register gives start & ~start_q. Holding
//    start high launches one run. Edges during RUN are dropped.
//  - FSM: IDLE -start_edge-> RUN; RUN -count done-> DONE; DONE -start_edge-> RUN.
//    State codes: IDLE=0, RUN=1, DONE=2.
//  - RUN length: ADD = 1 cycle; MULT and MAC = WIDTH cycles (one multiplier bit per cycle,
//    LSB first). busy=1 exactly in RUN. done=1 in DONE only.
//  - Result width RES_W: ADD WIDTH+1; MULT 2*WIDTH; MAC ACC_WIDTH. Unused high bits read 0.
//  - ADD: result = op_a + op_b, zero-extended.
//  - MULT: result = op_a * op_b, unsigned. result is updated on the RUN->DONE edge only.
//  - MAC: acc <= acc + op_a*op_b on the RUN->DONE edge, modulo 2^ACC_WIDTH.
//    overflow is set on wrap and stays set until acc_clr or reset.
//  - acc_clr (MAC only): zeroes acc, result and overflow when sampled in IDLE or DONE.
//    It is ignored in RUN. If start_edge and acc_clr arrive in the same cycle, the clear
//    applies first and the run proceeds from acc=0.
//  - Readback: uo_out = result[8*byte_sel +: 8]. A byte above RES_W reads 8'h00.
//    The value is stable in DONE and IDLE and holds its previous value during RUN.
//  - ena=0: FSM, counter, operands, start_q and acc all freeze. Outputs keep their values.
//  - Reset mid-RUN aborts the operation. There is no partial result; the block comes up in IDLE.
// STRUCTURE
//  - Package size_exploration_pkg holds the FSM state enum (IDLE/RUN/DONE), the mode name
//    constants, and a function res_width(MODE, WIDTH, ACC_WIDTH).
//  - Sub-module seq_shift_add_mult (WIDTH):
//    - ports clk, rst_n, en, load, a, b, busy, done_pulse, product[2*WIDTH-1:0];
//    - behaviour: a WIDTH-cycle shift-add multiplier.
//    - It is reused for MULT and MAC.
//    - ADD stays inline in the top.
// TESTING (WIDTH=8, ACC_WIDTH=20)
//  1. MULT: shift A=0xB5, B=0x3C, pulse start
//     -> busy for 8 cycles, then done=1; result 0x2A6C; byte_sel 0 -> 0x6C, 1 -> 0x2A, 2 -> 0x00.
//  2. ADD: A=0xFF, B=0x01, start -> busy for 1 cycle; result 0x100; byte_sel 1 -> 0x01.
//  3. MAC: acc_clr, then 17 runs of 0xFF*0xFF
//     -> after 16 runs result 0xFE010 with overflow=0;
//     -> after the 17th, result 0x0DE11 with overflow=1;
//     -> acc_clr -> result 0, overflow 0.
//  4. Robustness during RUN:
//     - start held high for 20 cycles -> exactly one run;
//     - shift_en toggled during RUN -> operands unchanged;
//     - a second start edge during RUN -> ignored.
//  5. Reset at the 4th busy cycle of a MULT
//     -> outputs go 0 immediately; state IDLE after release; a new run gives the correct product.
//  6. ena=0 for 5 cycles mid-RUN -> busy stays 1 and the counter freezes;
//     after ena=1 the total RUN length is 8 enabled cycles and the product is correct.

Source files
------------

// File: rtl/size_exploration_pkg.sv
// Shared types and constants for the size-exploration sequential harness.
// Mode names are 32-bit packed strings so they can be compared at elaboration time.
package size_exploration_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [31:0] MODE_ADD  = {8'h00, "ADD"};
    localparam logic [31:0] MODE_MULT = "MULT";
    localparam logic [31:0] MODE_MAC  = {8'h00, "MAC"};

    function automatic int unsigned res_width(input logic [31:0] mode,
                                              input int unsigned width,
                                              input int unsigned acc_width);
        if (mode == MODE_ADD)      return width + 1;
        else if (mode == MODE_MAC) return acc_width;
        else                       return 2 * width;
    endfunction

endpackage

// File: rtl/size_exploration_seq_harness_mult.sv
// WIDTH-cycle unsigned shift-add multiplier. Bit 0 of the multiplier is consumed on
// the load edge, so done_pulse rises one cycle before the WIDTH-th cycle after load ends.
module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [2*WIDTH-1:0]   product
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] step_sum;
    logic [2*WIDTH-1:0] a_ext;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign a_ext    = {{WIDTH{1'b0}}, a};
    assign partial  = mplier[0] ? mcand : '0;
    assign step_sum = acc + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand      <= '0;
            acc        <= '0;
            mplier     <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            product    <= '0;
        end else if (en) begin
            done_pulse <= 1'b0;
            if (load && !busy) begin
                acc    <= b[0] ? a_ext : '0;
                mcand  <= a_ext << 1;
                mplier <= b >> 1;
                cnt    <= CNT_W'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= step_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (cnt == LAST) begin
                    busy       <= 1'b0;
                    done_pulse <= 1'b1;
                    product    <= step_sum;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/size_exploration_seq_harness.sv
// Tile top: serial operand load, start/busy/done FSM around an ADD, MULT or MAC kernel,
// registered result read back byte-wise on uo_out.
module size_exploration_seq_harness
    import size_exploration_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] MODE      = MODE_MULT,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int unsigned RES_W  = res_width(MODE, WIDTH, ACC_WIDTH);
    localparam bit          IS_ADD = (MODE == MODE_ADD);
    localparam bit          IS_MAC = (MODE == MODE_MAC);

    fsm_state_t         state;
    logic               start_q;
    logic               overflow;
    logic [WIDTH-1:0]   op_a, op_b, op_a_nxt, op_b_nxt;
    logic [RES_W-1:0]   result;
    logic [RES_W:0]     mac_sum;
    logic [63:0]        res_ext;
    logic               start_edge, shift_now, mult_load;
    logic               mult_busy, mult_done;
    logic [2*WIDTH-1:0] mult_product;
    logic               unused_sink;

    assign start_edge = ui_in[3] & ~start_q;
    assign shift_now  = ui_in[2] && (state != RUN);
    // The multiplier loads the post-shift operands so a shift and a start in the same
    // cycle behave exactly like the inline ADD path.
    assign op_a_nxt   = shift_now ? {op_a[WIDTH-2:0], ui_in[0]} : op_a;
    assign op_b_nxt   = shift_now ? {op_b[WIDTH-2:0], ui_in[1]} : op_b;
    assign mult_load  = start_edge && (state != RUN);
    assign mac_sum    = {1'b0, result} + (RES_W + 1)'(mult_product);

    if (IS_ADD) begin : g_add_only
        assign mult_busy    = 1'b0;
        assign mult_done    = 1'b0;
        assign mult_product = '0;
    end else begin : g_mult
        seq_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (ena),
            .load       (mult_load),
            .a          (op_a_nxt),
            .b          (op_b_nxt),
            .busy       (mult_busy),
            .done_pulse (mult_done),
            .product    (mult_product)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            start_q <= ui_in[3];
            op_a    <= op_a_nxt;
            op_b    <= op_b_nxt;
            case (state)
                IDLE, DONE: begin
                    if (IS_MAC && ui_in[7]) begin
                        result   <= '0;
                        overflow <= 1'b0;
                    end
                    if (start_edge) state <= RUN;
                end
                RUN: begin
                    if (IS_ADD) begin
                        result <= RES_W'({1'b0, op_a} + {1'b0, op_b});
                        state  <= DONE;
                    end else if (mult_done) begin
                        if (IS_MAC) begin
                            result   <= mac_sum[RES_W-1:0];
                            overflow <= overflow | mac_sum[RES_W];
                        end else begin
                            result <= RES_W'(mult_product);
                        end
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_ext     = 64'(result);
    assign uo_out      = res_ext[{ui_in[6:4], 3'b000} +: 8];
    assign uio_out     = {3'b000, state, overflow, state == DONE, state == RUN};
    assign uio_oe      = 8'hFF;
    assign unused_sink = &{1'b0, uio_in, mult_busy, mult_load};

endmodule

// File: tb/tb_size_exploration_seq_harness.sv
// Bench for the sequential harness: ADD, MULT and MAC instances share one stimulus stream
// and are compared against a plain-arithmetic reference model.
module tb_size_exploration_seq_harness;
    import size_exploration_pkg::*;

    localparam int W  = 8;
    localparam int AW = 20;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_add, uo_mul, uo_mac;
    logic [7:0] st_add, st_mul, st_mac;
    logic [7:0] oe_add, oe_mul, oe_mac;

    int total = 0;
    int bad   = 0;
    int bc_add, bc_mul, bc_mac;
    longint unsigned m_acc;
    bit              m_ovf;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [8:0]  e_add;
        logic [15:0] e_mul;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    size_exploration_seq_harness #(.WIDTH(W), .MODE(MODE_ADD), .ACC_WIDTH(AW)) u_add (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_add),
        .uio_in(uio_in), .uio_out(st_add), .uio_oe(oe_add));
    size_exploration_seq_harness #(.WIDTH(W), .MODE(MODE_MULT), .ACC_WIDTH(AW)) u_mul (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_mul),
        .uio_in(uio_in), .uio_out(st_mul), .uio_oe(oe_mul));
    size_exploration_seq_harness #(.WIDTH(W), .MODE(MODE_MAC), .ACC_WIDTH(AW)) u_mac (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_mac),
        .uio_in(uio_in), .uio_out(st_mac), .uio_oe(oe_mac));

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample busy flags, then advance one clock and settle 1 ns past the edge.
    task automatic step();
        bc_add += int'(st_add[0]);
        bc_mul += int'(st_mul[0]);
        bc_mac += int'(st_mac[0]);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bc();
        bc_add = 0;
        bc_mul = 0;
        bc_mac = 0;
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        for (int i = W - 1; i >= 0; i--) begin
            ui_in = 8'h04 | {6'b000000, b[i], a[i]};
            step();
        end
        ui_in = 8'h00;
    endtask

    task automatic pulse_start();
        ui_in = 8'h08;
        step();
        ui_in = 8'h00;
    endtask

    task automatic acc_clear();
        ui_in = 8'h80;
        step();
        ui_in = 8'h00;
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_run(input logic [7:0] a, input logic [7:0] b);
        longint unsigned sum;
        sum = m_acc + longint'(a) * longint'(b);
        if (sum >= (64'd1 << AW)) m_ovf = 1'b1;
        m_acc = sum % (64'd1 << AW);
    endtask

    task automatic read_res(output longint unsigned ra, output longint unsigned rm,
                            output longint unsigned rc);
        ra = 0;
        rm = 0;
        rc = 0;
        for (int s = 0; s < 8; s++) begin
            ui_in = {1'b0, 3'(s), 4'b0000};
            #1;
            ra |= {56'd0, uo_add} << (8 * s);
            rm |= {56'd0, uo_mul} << (8 * s);
            rc |= {56'd0, uo_mac} << (8 * s);
        end
        ui_in = 8'h00;
    endtask

    task automatic check_run(input string name, input longint unsigned e_add,
                             input longint unsigned e_mul, input bit chk_add,
                             input int e_bm, input int e_ba);
        longint unsigned ra, rm, rc;
        read_res(ra, rm, rc);
        if (chk_add) begin
            check({name, "_add"}, ra, e_add);
            check({name, "_add_busy"}, longint'(bc_add), longint'(e_ba));
            check({name, "_add_st"}, {56'd0, st_add}, 64'h12);
        end
        check({name, "_mul"}, rm, e_mul);
        check({name, "_mul_busy"}, longint'(bc_mul), longint'(e_bm));
        check({name, "_mul_st"}, {56'd0, st_mul}, 64'h12);
        check({name, "_mac"}, rc, m_acc);
        check({name, "_mac_busy"}, longint'(bc_mac), longint'(e_bm));
        check({name, "_mac_st"}, {56'd0, st_mac}, m_ovf ? 64'h16 : 64'h12);
    endtask

    task automatic full_run(input string name, input logic [7:0] a, input logic [7:0] b);
        load_ops(a, b);
        clear_bc();
        pulse_start();
        for (int k = 0; k < 12; k++) step();
        model_run(a, b);
        check_run(name, {56'd0, a} + {56'd0, b}, {56'd0, a} * {56'd0, b}, 1'b1, W, 1);
    endtask

    initial begin
        logic [7:0] ra8, rb8;
        logic [7:0] pat[6];
        longint unsigned xa, xm, xc;

        vecs[0] = '{8'hB5, 8'h3C, 9'h0F1, 16'h2A6C};
        vecs[1] = '{8'hFF, 8'h01, 9'h100, 16'h00FF};
        vecs[2] = '{8'h00, 8'h00, 9'h000, 16'h0000};
        vecs[3] = '{8'hFF, 8'hFF, 9'h1FE, 16'hFE01};
        vecs[4] = '{8'h80, 8'h02, 9'h082, 16'h0100};
        vecs[5] = '{8'h01, 8'h80, 9'h081, 16'h0080};
        vecs[6] = '{8'h7F, 8'h81, 9'h100, 16'h3FFF};
        pat = '{8'h07, 8'h04, 8'h0F, 8'h05, 8'h0C, 8'h00};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_acc  = 0;
        m_ovf  = 1'b0;
        clear_bc();
        #2;
        check("rst_uo", {40'd0, uo_add, uo_mul, uo_mac}, 64'd0);
        check("rst_st", {40'd0, st_add, st_mul, st_mac}, 64'd0);
        check("rst_oe", {40'd0, oe_add, oe_mul, oe_mac}, 64'hFFFFFF);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed vector table (MAC tracked by the model).
        for (int i = 0; i < 7; i++) begin
            load_ops(vecs[i].a, vecs[i].b);
            clear_bc();
            pulse_start();
            for (int k = 0; k < 12; k++) step();
            model_run(vecs[i].a, vecs[i].b);
            check_run($sformatf("vec%0d", i), {55'd0, vecs[i].e_add}, {48'd0, vecs[i].e_mul},
                      1'b1, W, 1);
        end

        // MAC wrap: 17 runs of 0xFF*0xFF from a cleared accumulator.
        acc_clear();
        read_res(xa, xm, xc);
        check("mac_clr0", xc, 64'd0);
        load_ops(8'hFF, 8'hFF);
        for (int r = 1; r <= 17; r++) begin
            clear_bc();
            pulse_start();
            for (int k = 0; k < 12; k++) step();
            model_run(8'hFF, 8'hFF);
            if (r >= 16) begin
                read_res(xa, xm, xc);
                check($sformatf("mac_run%0d", r), xc, (r == 16) ? 64'hFE010 : 64'h0DE11);
                check($sformatf("mac_ovf%0d", r), {63'd0, st_mac[2]}, (r == 16) ? 64'd0 : 64'd1);
            end
        end
        acc_clear();
        read_res(xa, xm, xc);
        check("mac_clr_res", xc, 64'd0);
        check("mac_clr_st", {56'd0, st_mac}, 64'h12);

        // Start held high for 20 cycles launches exactly one run.
        ra8 = 8'(($urandom % 255) + 1);
        rb8 = 8'(($urandom % 255) + 1);
        load_ops(ra8, rb8);
        clear_bc();
        ui_in = 8'h08;
        for (int k = 0; k < 20; k++) step();
        ui_in = 8'h00;
        step();
        model_run(ra8, rb8);
        check_run("held", {56'd0, ra8} + {56'd0, rb8}, {56'd0, ra8} * {56'd0, rb8}, 1'b1, W, 1);

        // shift_en toggles and a second start edge during RUN are ignored.
        ra8 = 8'($urandom);
        rb8 = 8'($urandom);
        load_ops(ra8, rb8);
        clear_bc();
        pulse_start();
        for (int j = 0; j < 6; j++) begin
            ui_in = pat[j];
            step();
        end
        ui_in = 8'h00;
        for (int k = 0; k < 8; k++) step();
        model_run(ra8, rb8);
        check_run("runnoise", 0, {56'd0, ra8} * {56'd0, rb8}, 1'b0, W, 0);

        // Reset in the 4th busy cycle of a run.
        ra8 = 8'($urandom);
        rb8 = 8'($urandom);
        load_ops(ra8, rb8);
        pulse_start();
        for (int k = 0; k < 3; k++) step();
        check("midrun_busy", {63'd0, st_mul[0]}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_uo", {40'd0, uo_add, uo_mul, uo_mac}, 64'd0);
        check("midrst_st", {40'd0, st_add, st_mul, st_mac}, 64'd0);
        m_acc = 0;
        m_ovf = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("postrst_idle", {40'd0, st_add, st_mul, st_mac}, 64'd0);
        full_run("postrst", ra8, rb8);

        // ena low for 5 cycles mid-run freezes the FSM.
        ra8 = 8'($urandom);
        rb8 = 8'($urandom);
        load_ops(ra8, rb8);
        pulse_start();
        for (int k = 0; k < 3; k++) step();
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("frz_busy%0d", k), {63'd0, st_mul[0]}, 64'd1);
            step();
        end
        ena = 1'b1;
        clear_bc();
        for (int k = 0; k < 10; k++) step();
        model_run(ra8, rb8);
        check_run("frz", {56'd0, ra8} + {56'd0, rb8}, {56'd0, ra8} * {56'd0, rb8}, 1'b1, W - 3, 0);

        // Randomized runs with occasional accumulator clears.
        for (int n = 0; n < 16; n++) begin
            ra8 = 8'($urandom_range(255));
            rb8 = 8'($urandom_range(255));
            if ($urandom_range(3) == 0) acc_clear();
            full_run($sformatf("rnd%0d", n), ra8, rb8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
